mem_buf_resp: RTL and testbench
===============================

MEM_BUF_RESP -- requirements
Module: mem_buf_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request-queue entries (power of 2, ≥2).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_vld  in  1  request valid from the ALU issue slot.
REQ-005 SHALL have port mem_para  in  `MEMB_PARA (9)  {rd[4:0], funct3[2:0], is_store}.
REQ-006 SHALL have port mem_addr  in  `XLEN  effective byte address.
REQ-007 SHALL have port mem_wdata  in  `XLEN  store data, right-aligned.
REQ-008 SHALL have port mem_full  out  1  queue full; producer must not assert mem_vld.
REQ-009 SHALL have port mem_busy  out  1  queue non-empty or transaction in flight.
REQ-010 SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out `XLEN (word-aligned), dmem_be out 4, dmem_wdata out `XLEN: data-bus request.
REQ-011 SHALL have ports dmem_gnt in 1, dmem_rvld in 1, dmem_rdata in `XLEN: bus grant and read return.
REQ-012 SHALL have ports mem_rg_vld out 1, mem_rg_sel out 5, mem_rg_data out `XLEN: load writeback to register file.
REQ-013 SHALL have port mem_err  out  1  one-cycle pulse on a dropped misaligned access.

Function
REQ-014 SHALL enqueue {mem_para, mem_addr, mem_wdata} on any clk edge with mem_vld=1 and mem_full=0; mem_vld while full is ignored with no state change.
REQ-015 SHALL drive mem_full=1 when count==DEPTH, with no same-cycle bypass on a pop.
REQ-016 SHALL pointer-wrap modulo DEPTH and SHALL process requests strictly in order, with at most one bus transaction outstanding.
REQ-017 SHALL implement an FSM with states IDLE, REQ, WAIT.
REQ-018 IDLE SHALL move to REQ one cycle after the queue becomes non-empty, and never move in the enqueue cycle itself.
REQ-019 In REQ, dmem_req=1 and all dmem_* outputs SHALL hold stable until dmem_gnt=1.
REQ-020 On a store grant, the FSM SHALL pop the head and go to REQ if more entries remain, otherwise to IDLE.
REQ-021 On a load grant, the FSM SHALL go to WAIT.
REQ-022 In WAIT, dmem_rvld=1 SHALL pop the head and go to REQ or IDLE as in REQ-020; dmem_rvld outside WAIT is ignored.
REQ-023 dmem_addr SHALL be {addr[31:2],2'b00}.
REQ-024 dmem_be SHALL be byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111.
REQ-025 dmem_wdata SHALL replicate the byte (x4) or half (x2) across lanes.
REQ-026 Misaligned accesses (half with addr[0]=1; word with addr[1:0]≠0) SHALL be popped in REQ without asserting dmem_req, and SHALL pulse mem_err for one cycle with no writeback.
REQ-027 Load data SHALL be the lane selected by addr[1:0]: funct3 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; any other funct3 is treated as LW.
REQ-028 mem_rg_vld SHALL be a registered pulse one cycle after dmem_rvld, with mem_rg_sel=rd and mem_rg_data the extended value; it stays 0 when rd=0.
REQ-029 mem_busy SHALL equal (count≠0)|(state≠IDLE)|mem_rg_vld.

Reset
REQ-030 rst=1 SHALL asynchronously clear pointers, count, state (IDLE), mem_rg_vld, mem_err, dmem_req and dmem_we, and SHALL zero dmem_addr/be/wdata and mem_rg_sel/data.
REQ-031 Reset mid-transaction SHALL discard all queued and in-flight requests; a later dmem_rvld is ignored.

Structure
REQ-032 `XLEN, `MEMB_PARA, the funct3 load/store codes and the default DEPTH SHALL live in define.v.
REQ-033 Queue storage SHALL be the sub-module mem_buf_fifo (DEPTH x (9+2*`XLEN), push/pop/full/empty/head); the FSM and lane logic SHALL stay in mem_buf_resp.

Verification
REQ-034 SW addr 0x100, data 0xDEADBEEF, gnt after 2 stall cycles: dmem_req held 3 cycles, be=1111, we=1, addr 0x100, queue empty afterwards.
REQ-035 LB rd=5, addr 0x103, rdata 0x80FF_FF_FF: mem_rg_vld the cycle after rvld, sel=5, data 0xFFFFFF80; LBU gives 0x00000080.
REQ-036 Push 5 requests back-to-back with DEPTH=4 and gnt=0: mem_full=1 after 4, 5th ignored, then exactly 4 transactions in order on release.
REQ-037 LH at 0x101: no dmem_req, single mem_err pulse, no writeback, next entry issues.
REQ-038 Assert rst while in WAIT with 2 entries queued: all outputs 0 immediately, a subsequent rvld produces no writeback, and mem_busy=0.
REQ-039 SB 0x12 at 0x102 then LW rd=0: be=0100, wdata 0x12121212; the load bus cycle occurs with no mem_rg_vld.

Source files
------------

// File: rtl/mem_buf_resp_pkg.sv
// Shared widths, funct3 codes and state/size encodings for the memory response buffer.
package mem_buf_resp_pkg;

   localparam int XLEN       = 32;
   localparam int MEMB_PARA  = 9;
   localparam int MEMB_DEPTH = 4;
   localparam int MEMB_ENTRY = MEMB_PARA + 2 * XLEN;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_t;

   // Loads and stores share funct3[1:0] for width; unknown codes fall back to word.
   function automatic size_t access_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/mem_buf_fifo.sv
// Request queue: DEPTH entries, power-of-two pointers wrap naturally.
module mem_buf_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    cnt_q;

   // Entry storage needs no reset; the count gates every use of it.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/mem_buf_resp.sv
// Load/store request buffer: queues ALU memory ops, issues them one at a time on
// the data bus, handles lane steering and load extension, drops misaligned ops.
module mem_buf_resp
   import mem_buf_resp_pkg::*;
#(
   parameter int DEPTH = MEMB_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_vld,
   input  logic [MEMB_PARA-1:0] mem_para,
   input  logic [XLEN-1:0]      mem_addr,
   input  logic [XLEN-1:0]      mem_wdata,
   output logic                 mem_full,
   output logic                 mem_busy,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [XLEN-1:0]      dmem_addr,
   output logic [3:0]           dmem_be,
   output logic [XLEN-1:0]      dmem_wdata,
   input  logic                 dmem_gnt,
   input  logic                 dmem_rvld,
   input  logic [XLEN-1:0]      dmem_rdata,
   output logic                 mem_rg_vld,
   output logic [4:0]           mem_rg_sel,
   output logic [XLEN-1:0]      mem_rg_data,
   output logic                 mem_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t                state_q;
   logic                  rg_vld_q;
   logic [4:0]            rg_sel_q;
   logic [XLEN-1:0]       rg_data_q;
   logic                  err_q;

   logic                  push_ok;
   logic                  pop;
   logic                  q_full;
   logic                  q_empty;
   logic [MEMB_ENTRY-1:0] head;
   logic [CW-1:0]         q_count;

   logic [4:0]            h_rd;
   logic [2:0]            h_f3;
   logic                  h_st;
   logic [XLEN-1:0]       h_addr;
   logic [XLEN-1:0]       h_wdata;
   logic [1:0]            sh;
   logic                  mis;
   logic [3:0]            be;
   logic [XLEN-1:0]       wd;
   logic [7:0]            lane_b;
   logic [15:0]           lane_h;
   logic [XLEN-1:0]       ld_data;
   logic                  remain;
   logic                  bus_act;

   assign push_ok = mem_vld & ~q_full;

   mem_buf_fifo #(.DEPTH(DEPTH), .WIDTH(MEMB_ENTRY)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_ok),
      .pop   (pop),
      .din   ({mem_para, mem_addr, mem_wdata}),
      .full  (q_full),
      .empty (q_empty),
      .head  (head),
      .count (q_count)
   );

   assign {h_rd, h_f3, h_st} = head[MEMB_ENTRY-1 -: MEMB_PARA];
   assign h_addr  = head[2*XLEN-1 -: XLEN];
   assign h_wdata = head[XLEN-1:0];
   assign sh      = h_addr[1:0];

   // Byte-enable, store-lane replication and alignment check for the head entry.
   always_comb begin
      mis = 1'b0;
      be  = 4'b1111;
      wd  = h_wdata;
      case (access_size(h_f3))
         SZ_B: begin
            be = 4'b0001 << sh;
            wd = {4{h_wdata[7:0]}};
         end
         SZ_H: begin
            be  = 4'b0011 << sh;
            wd  = {2{h_wdata[15:0]}};
            mis = sh[0];
         end
         default: begin
            be  = 4'b1111;
            mis = |sh;
         end
      endcase
   end

   // Select the addressed lane of the read return and extend it.
   always_comb begin
      lane_h = sh[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (sh)
         2'd0:    lane_b = dmem_rdata[7:0];
         2'd1:    lane_b = dmem_rdata[15:8];
         2'd2:    lane_b = dmem_rdata[23:16];
         default: lane_b = dmem_rdata[31:24];
      endcase
      case (h_f3)
         F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   ld_data = {24'd0, lane_b};
         F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   ld_data = {16'd0, lane_h};
         F3_W:    ld_data = dmem_rdata;
         default: ld_data = dmem_rdata;
      endcase
   end

   // Whether another entry is waiting once the head retires (counting a same-cycle push).
   assign remain  = (q_count > CW'(1)) | push_ok;
   assign bus_act = (state_q == ST_REQ) & ~mis;
   assign pop     = ((state_q == ST_REQ) & (mis | (dmem_gnt & h_st))) |
                    ((state_q == ST_WAIT) & dmem_rvld);

   // Issue sequencer plus registered writeback and error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rg_vld_q  <= 1'b0;
         rg_sel_q  <= '0;
         rg_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         rg_vld_q <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!q_empty) state_q <= ST_REQ;
            end
            ST_REQ: begin
               if (mis) begin
                  err_q   <= 1'b1;
                  state_q <= remain ? ST_REQ : ST_IDLE;
               end else if (dmem_gnt) begin
                  if (h_st) state_q <= remain ? ST_REQ : ST_IDLE;
                  else      state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dmem_rvld) begin
                  rg_vld_q  <= (h_rd != 5'd0);
                  rg_sel_q  <= h_rd;
                  rg_data_q <= ld_data;
                  state_q   <= remain ? ST_REQ : ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign dmem_req    = bus_act;
   assign dmem_we     = bus_act & h_st;
   assign dmem_addr   = bus_act ? {h_addr[XLEN-1:2], 2'b00} : '0;
   assign dmem_be     = bus_act ? be : 4'b0000;
   assign dmem_wdata  = bus_act ? wd : '0;

   assign mem_full    = q_full;
   assign mem_busy    = ~q_empty | (state_q != ST_IDLE) | rg_vld_q;
   assign mem_rg_vld  = rg_vld_q;
   assign mem_rg_sel  = rg_sel_q;
   assign mem_rg_data = rg_data_q;
   assign mem_err     = err_q;

endmodule

// File: tb/tb_mem_buf_resp.sv
// Directed bench for mem_buf_resp: stores, loads, full queue, misalignment, reset.
module tb_mem_buf_resp;
   import mem_buf_resp_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 mem_vld;
   logic [MEMB_PARA-1:0] mem_para;
   logic [XLEN-1:0]      mem_addr;
   logic [XLEN-1:0]      mem_wdata;
   logic                 mem_full;
   logic                 mem_busy;
   logic                 dmem_req;
   logic                 dmem_we;
   logic [XLEN-1:0]      dmem_addr;
   logic [3:0]           dmem_be;
   logic [XLEN-1:0]      dmem_wdata;
   logic                 dmem_gnt;
   logic                 dmem_rvld;
   logic [XLEN-1:0]      dmem_rdata;
   logic                 mem_rg_vld;
   logic [4:0]           mem_rg_sel;
   logic [XLEN-1:0]      mem_rg_data;
   logic                 mem_err;

   int errors = 0;
   int checks = 0;

   mem_buf_resp #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_vld     (mem_vld),
      .mem_para    (mem_para),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_full    (mem_full),
      .mem_busy    (mem_busy),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_be     (dmem_be),
      .dmem_wdata  (dmem_wdata),
      .dmem_gnt    (dmem_gnt),
      .dmem_rvld   (dmem_rvld),
      .dmem_rdata  (dmem_rdata),
      .mem_rg_vld  (mem_rg_vld),
      .mem_rg_sel  (mem_rg_sel),
      .mem_rg_data (mem_rg_data),
      .mem_err     (mem_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One-cycle enqueue; entered and left at a falling edge.
   task automatic push(input logic [4:0] rd, input logic [2:0] f3, input logic st,
                       input logic [31:0] addr, input logic [31:0] wd);
      mem_vld   = 1'b1;
      mem_para  = {rd, f3, st};
      mem_addr  = addr;
      mem_wdata = wd;
      @(negedge clk);
      mem_vld   = 1'b0;
   endtask

   // Bounded wait for a bus request; an expired bound is a failure.
   task automatic wait_req(input string tag);
      int n = 0;
      while (!dmem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL %s_wait_req: dmem_req=%b after %0d cycles, need 1", tag, dmem_req, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({dmem_req, dmem_we, mem_rg_vld, mem_err, mem_full, mem_busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: req/we/rgv/err/full/busy=%b need 000000",
                  {dmem_req, dmem_we, mem_rg_vld, mem_err, mem_full, mem_busy});
      end
      checks++;
      if (dmem_addr !== 32'h0 || dmem_be !== 4'h0 || dmem_wdata !== 32'h0 ||
          mem_rg_sel !== 5'h0 || mem_rg_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h be=%h wdata=%h sel=%h data=%h need all 0",
                  dmem_addr, dmem_be, dmem_wdata, mem_rg_sel, mem_rg_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store();
      int n = 0;
      dmem_gnt = 1'b0;
      push(5'd0, 3'b010, 1'b1, 32'h100, 32'hDEADBEEF);
      checks++;
      if (dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL sw_enq_cycle_req: got %b need 0", dmem_req);
      end
      wait_req("sw");
      checks++;
      if (dmem_we !== 1'b1 || dmem_be !== 4'b1111 || dmem_addr !== 32'h100 ||
          dmem_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL sw_bus: we=%b be=%b addr=%h wdata=%h need 1 1111 00000100 deadbeef",
                  dmem_we, dmem_be, dmem_addr, dmem_wdata);
      end
      repeat (2) begin
         if (dmem_req) n++;
         @(negedge clk);
      end
      if (dmem_req) n++;
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL sw_req_cycles: got %0d need 3", n);
      end
      checks++;
      if (dmem_req !== 1'b0 || mem_busy !== 1'b0 || mem_full !== 1'b0) begin
         errors++;
         $display("FAIL sw_done: req=%b busy=%b full=%b need 0 0 0", dmem_req, mem_busy, mem_full);
      end
      // A read return with nothing outstanding must be ignored.
      dmem_rvld  = 1'b1;
      dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      dmem_rvld = 1'b0;
      checks++;
      if (mem_rg_vld !== 1'b0 || mem_busy !== 1'b0) begin
         errors++;
         $display("FAIL stray_rvld: rg_vld=%b busy=%b need 0 0", mem_rg_vld, mem_busy);
      end
   endtask

   task automatic test_load();
      logic [2:0]  f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
      logic [31:0] addr [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104, 32'h100};
      logic [31:0] rd_v [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80010000, 32'h80010000,
                                32'h12345678, 32'h1234567F};
      logic [31:0] exp  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                32'h12345678, 32'h0000007F};
      logic [3:0]  ebe  [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0001};
      logic [31:0] eaddr[6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 32'h100};
      for (int i = 0; i < 6; i++) begin
         push(5'd5, f3[i], 1'b0, addr[i], 32'h0);
         wait_req($sformatf("ld%0d", i));
         checks++;
         if (dmem_we !== 1'b0 || dmem_be !== ebe[i] || dmem_addr !== eaddr[i]) begin
            errors++;
            $display("FAIL ld%0d_bus: we=%b be=%b addr=%h need 0 %b %h",
                     i, dmem_we, dmem_be, dmem_addr, ebe[i], eaddr[i]);
         end
         dmem_gnt = 1'b1;
         @(negedge clk);
         dmem_gnt = 1'b0;
         checks++;
         if (dmem_req !== 1'b0 || mem_rg_vld !== 1'b0) begin
            errors++;
            $display("FAIL ld%0d_wait: req=%b rg_vld=%b need 0 0", i, dmem_req, mem_rg_vld);
         end
         dmem_rvld  = 1'b1;
         dmem_rdata = rd_v[i];
         @(negedge clk);
         dmem_rvld = 1'b0;
         checks++;
         if (mem_rg_vld !== 1'b1 || mem_rg_sel !== 5'd5 || mem_rg_data !== exp[i]) begin
            errors++;
            $display("FAIL ld%0d_wb: vld=%b sel=%0d data=%h need 1 5 %h",
                     i, mem_rg_vld, mem_rg_sel, mem_rg_data, exp[i]);
         end
         @(negedge clk);
         checks++;
         if (mem_rg_vld !== 1'b0 || mem_busy !== 1'b0) begin
            errors++;
            $display("FAIL ld%0d_after: vld=%b busy=%b need 0 0", i, mem_rg_vld, mem_busy);
         end
      end
   endtask

   task automatic test_full();
      logic [31:0] got_a [8];
      logic [31:0] got_d [8];
      int n = 0;
      dmem_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mem_vld   = 1'b1;
         mem_para  = {5'd0, 3'b010, 1'b1};
         mem_addr  = 32'h10 * (i + 1);
         mem_wdata = i;
         @(negedge clk);
         if (i == 3) begin
            checks++;
            if (mem_full !== 1'b1) begin
               errors++;
               $display("FAIL full_after4: got %b need 1", mem_full);
            end
         end
      end
      mem_vld = 1'b0;
      checks++;
      if (mem_full !== 1'b1 || mem_busy !== 1'b1 || dmem_addr !== 32'h10) begin
         errors++;
         $display("FAIL full_hold: full=%b busy=%b addr=%h need 1 1 00000010",
                  mem_full, mem_busy, dmem_addr);
      end
      dmem_gnt = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (dmem_req && n < 8) begin
            got_a[n] = dmem_addr;
            got_d[n] = dmem_wdata;
            n++;
         end
         @(negedge clk);
      end
      dmem_gnt = 1'b0;
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL full_txn_count: got %0d need 4", n);
      end
      for (int j = 0; j < 4 && j < n; j++) begin
         checks++;
         if (got_a[j] !== 32'h10 * (j + 1) || got_d[j] !== j) begin
            errors++;
            $display("FAIL full_order%0d: addr=%h wdata=%h need %h %h",
                     j, got_a[j], got_d[j], 32'h10 * (j + 1), j);
         end
      end
      checks++;
      if (mem_full !== 1'b0 || mem_busy !== 1'b0) begin
         errors++;
         $display("FAIL full_drained: full=%b busy=%b need 0 0", mem_full, mem_busy);
      end
   endtask

   task automatic test_misaligned();
      int errs = 0;
      int wbs = 0;
      logic seen = 1'b0;
      logic [31:0] first_a = 32'h0;
      logic first_we = 1'b0;
      dmem_gnt = 1'b0;
      push(5'd3, 3'b001, 1'b0, 32'h101, 32'h0);
      push(5'd0, 3'b010, 1'b1, 32'h200, 32'h5);
      for (int k = 0; k < 8; k++) begin
         if (mem_err) errs++;
         if (mem_rg_vld) wbs++;
         if (dmem_req && !seen) begin
            seen     = 1'b1;
            first_a  = dmem_addr;
            first_we = dmem_we;
         end
         @(negedge clk);
      end
      checks++;
      if (errs != 1) begin
         errors++;
         $display("FAIL mis_err_pulses: got %0d need 1", errs);
      end
      checks++;
      if (wbs != 0) begin
         errors++;
         $display("FAIL mis_writeback: got %0d need 0", wbs);
      end
      checks++;
      if (seen !== 1'b1 || first_a !== 32'h200 || first_we !== 1'b1) begin
         errors++;
         $display("FAIL mis_next_issue: seen=%b addr=%h we=%b need 1 00000200 1",
                  seen, first_a, first_we);
      end
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      checks++;
      if (mem_busy !== 1'b0 || mem_err !== 1'b0) begin
         errors++;
         $display("FAIL mis_done: busy=%b err=%b need 0 0", mem_busy, mem_err);
      end
   endtask

   task automatic test_reset_mid();
      dmem_gnt = 1'b0;
      push(5'd7, 3'b010, 1'b0, 32'h300, 32'h0);
      wait_req("rstmid");
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      push(5'd0, 3'b010, 1'b1, 32'h400, 32'h1);
      push(5'd0, 3'b010, 1'b1, 32'h404, 32'h2);
      checks++;
      if (mem_busy !== 1'b1 || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_pre: busy=%b req=%b need 1 0", mem_busy, dmem_req);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({dmem_req, dmem_we, mem_rg_vld, mem_err, mem_full, mem_busy} !== 6'b0 ||
          dmem_addr !== 32'h0 || dmem_be !== 4'h0 || dmem_wdata !== 32'h0 ||
          mem_rg_sel !== 5'h0 || mem_rg_data !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_async: flags=%b addr=%h be=%h wdata=%h sel=%h data=%h need all 0",
                  {dmem_req, dmem_we, mem_rg_vld, mem_err, mem_full, mem_busy},
                  dmem_addr, dmem_be, dmem_wdata, mem_rg_sel, mem_rg_data);
      end
      @(negedge clk);
      rst        = 1'b0;
      @(negedge clk);
      dmem_rvld  = 1'b1;
      dmem_rdata = 32'h5555_5555;
      @(negedge clk);
      dmem_rvld = 1'b0;
      checks++;
      if (mem_rg_vld !== 1'b0 || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_rvld: rg_vld=%b req=%b need 0 0", mem_rg_vld, dmem_req);
      end
      @(negedge clk);
      checks++;
      if (mem_rg_vld !== 1'b0 || mem_busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_idle: rg_vld=%b busy=%b need 0 0", mem_rg_vld, mem_busy);
      end
   endtask

   task automatic test_sb_lw0();
      dmem_gnt = 1'b0;
      push(5'd0, 3'b000, 1'b1, 32'h102, 32'h0000_0012);
      push(5'd0, 3'b010, 1'b0, 32'h104, 32'h0);
      wait_req("sb");
      checks++;
      if (dmem_we !== 1'b1 || dmem_be !== 4'b0100 || dmem_addr !== 32'h100 ||
          dmem_wdata !== 32'h12121212) begin
         errors++;
         $display("FAIL sb_bus: we=%b be=%b addr=%h wdata=%h need 1 0100 00000100 12121212",
                  dmem_we, dmem_be, dmem_addr, dmem_wdata);
      end
      dmem_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h104 ||
          dmem_be !== 4'b1111) begin
         errors++;
         $display("FAIL lw0_bus: req=%b we=%b addr=%h be=%b need 1 0 00000104 1111",
                  dmem_req, dmem_we, dmem_addr, dmem_be);
      end
      @(negedge clk);
      dmem_gnt   = 1'b0;
      dmem_rvld  = 1'b1;
      dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      dmem_rvld = 1'b0;
      checks++;
      if (mem_rg_vld !== 1'b0) begin
         errors++;
         $display("FAIL lw0_no_wb: rg_vld=%b need 0", mem_rg_vld);
      end
      @(negedge clk);
      checks++;
      if (mem_rg_vld !== 1'b0 || mem_busy !== 1'b0) begin
         errors++;
         $display("FAIL lw0_idle: rg_vld=%b busy=%b need 0 0", mem_rg_vld, mem_busy);
      end
   endtask

   initial begin
      rst        = 1'b1;
      mem_vld    = 1'b0;
      mem_para   = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      dmem_gnt   = 1'b0;
      dmem_rvld  = 1'b0;
      dmem_rdata = '0;
      @(negedge clk);
      test_reset();
      test_store();
      test_load();
      test_full();
      test_misaligned();
      test_reset_mid();
      test_sb_lw0();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
